// File: rtl/game_ctrl.sv
// Session controller for the maze game core: round-robin move arbitration,
// game-end detection with saturating score counters and automatic restart.
module game_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [1:0]       dir0,
    output logic             ack0,
    input  logic             req1,
    input  logic [1:0]       dir1,
    output logic             ack1,
    input  logic             d,
    input  logic             win,
    output logic             n,
    output logic             s,
    output logic             e,
    output logic             w,
    output logic             game_reset,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] deaths,
    output logic             busy
);

    typedef enum logic [1:0] {RESTART, PLAY, OVER} state_t;

    // One counter serves both the 2-cycle RESTART and the HOLD_CYCLES OVER phase.
    localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]    OVER_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]    RST_LAST  = CW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last1;
    logic          game_end;
    logic          grant;
    logic [1:0]    grant_dir;

    assign game_end  = d | win;
    assign ack0      = (state == PLAY) && !game_end && req0 && (!req1 || last1);
    assign ack1      = (state == PLAY) && !game_end && req1 && (!req0 || !last1);
    assign grant     = ack0 | ack1;
    assign grant_dir = ack0 ? dir0 : dir1;

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RESTART;
            cnt        <= '0;
            game_reset <= 1'b1;
            busy       <= 1'b1;
            last1      <= 1'b1;
            n          <= 1'b0;
            s          <= 1'b0;
            e          <= 1'b0;
            w          <= 1'b0;
            wins       <= '0;
            deaths     <= '0;
        end else begin
            n <= grant && (grant_dir == 2'b00);
            s <= grant && (grant_dir == 2'b01);
            e <= grant && (grant_dir == 2'b10);
            w <= grant && (grant_dir == 2'b11);

            if (ack0)      last1 <= 1'b0;
            else if (ack1) last1 <= 1'b1;

            case (state)
                RESTART: begin
                    if (cnt == RST_LAST) begin
                        state      <= PLAY;
                        cnt        <= '0;
                        game_reset <= 1'b0;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PLAY: begin
                    if (game_end) begin
                        state <= OVER;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        // A death outranks a simultaneous win.
                        if (d) begin
                            if (deaths != CNT_MAX) deaths <= deaths + 1'b1;
                        end else if (wins != CNT_MAX) begin
                            wins <= wins + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (cnt == OVER_LAST) begin
                        state      <= RESTART;
                        cnt        <= '0;
                        game_reset <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= RESTART;
                    cnt        <= '0;
                    game_reset <= 1'b1;
                    busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a countdown-based model.
module tb_game_ctrl;

    localparam int HOLD  = 4;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk, reset;
    logic          req0, req1, d, win;
    logic [1:0]    dir0, dir1;
    logic          ack0, ack1, n, s, e, w, game_reset, busy;
    logic [CW-1:0] wins, deaths;

    int tests = 0;
    int fails = 0;

    // Model: hold_left = non-PLAY cycles still to come; last two of them are restart.
    int hold_left;
    int exp_move;      // 0..3 = N,S,E,W pulse now; 4 = no pulse
    int m_wins, m_deaths;
    bit turn1;         // requester 1 wins the next tie
    bit last_g0, last_g1;

    game_ctrl #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .dir0(dir0), .ack0(ack0),
        .req1(req1), .dir1(dir1), .ack1(ack1),
        .d(d), .win(win),
        .n(n), .s(s), .e(e), .w(w),
        .game_reset(game_reset), .wins(wins), .deaths(deaths), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic bit exp_ack0();
        return (hold_left == 0) && !(d || win) && req0 && (!req1 || !turn1);
    endfunction

    function automatic bit exp_ack1();
        return (hold_left == 0) && !(d || win) && req1 && (!req0 || turn1);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_left = 2;
            turn1     = 1'b0;
            exp_move  = 4;
            m_wins    = 0;
            m_deaths  = 0;
            last_g0   = 1'b0;
            last_g1   = 1'b0;
        end else begin
            last_g0  = exp_ack0();
            last_g1  = exp_ack1();
            exp_move = last_g0 ? int'(dir0) : (last_g1 ? int'(dir1) : 4);
            if (last_g0)      turn1 = 1'b1;
            else if (last_g1) turn1 = 1'b0;
            if (hold_left > 0) begin
                hold_left--;
            end else if (d || win) begin
                hold_left = HOLD + 2;
                if (d) m_deaths = (m_deaths < MAXC) ? m_deaths + 1 : m_deaths;
                else   m_wins   = (m_wins   < MAXC) ? m_wins + 1   : m_wins;
            end
        end
    end

    always @(negedge clk) begin
        check("ack0", ack0, exp_ack0());
        check("ack1", ack1, exp_ack1());
        check("n", n, exp_move == 0);
        check("s", s, exp_move == 1);
        check("e", e, exp_move == 2);
        check("w", w, exp_move == 3);
        check("game_reset", game_reset, (hold_left > 0) && (hold_left <= 2));
        check("busy", busy, hold_left > 0);
        check("wins", wins, m_wins);
        check("deaths", deaths, m_deaths);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_play();
        int k = 0;
        @(negedge clk);
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("wait_play_timeout", 1, 0);
    endtask

    task automatic end_game(input bit die);
        @(posedge clk); #1;
        d   = die;
        win = !die;
        @(posedge clk); #1;
        d   = 1'b0;
        win = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; d = 1'b0; win = 1'b0;
        dir0 = 2'b00; dir1 = 2'b00;

        // Reset release: two restart cycles, then PLAY.
        repeat (5) @(posedge clk);
        #1;
        check("rst_game_reset", game_reset, 1);
        check("rst_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk); check("rel_gr_c1", game_reset, 1);
        @(negedge clk); check("rel_gr_c2", game_reset, 1);
        @(negedge clk); check("rel_gr_play", game_reset, 0);
        check("rel_busy_play", busy, 0);

        // Contention from a fresh pointer: grants 0,1,0,1 -> N,W,N,W.
        @(posedge clk); #1;
        req0 = 1'b1; dir0 = 2'b00;
        req1 = 1'b1; dir1 = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("cont_ack0", ack0, (k % 2) == 0);
            check("cont_ack1", ack1, (k % 2) == 1);
            if (k > 0) begin
                check("cont_n", n, (k % 2) == 1);
                check("cont_w", w, (k % 2) == 0);
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        check("cont_last_w", w, 1);
        check("cont_last_n", n, 0);

        // Single move east from requester 0.
        @(posedge clk); #1;
        req0 = 1'b1; dir0 = 2'b10;
        @(negedge clk);
        check("single_ack0", ack0, 1);
        check("single_ack1", ack1, 0);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check("single_e", e, 1);
        check("single_nsw", {n, s, w}, 0);
        @(negedge clk);
        check("single_e_gone", e, 0);

        // Win with a held request from requester 1.
        @(posedge clk); #1;
        win = 1'b1; req1 = 1'b1; dir1 = 2'b01;
        @(negedge clk);
        check("win_ack_suppressed", ack1, 0);
        @(posedge clk); #1;
        win = 1'b0;
        for (int i = 0; i < HOLD + 2; i++) begin
            @(negedge clk);
            check("win_no_ack", ack1, 0);
            check("win_busy", busy, 1);
            check("win_gr", game_reset, i >= HOLD);
            if (i == 0) begin
                check("win_wins", wins, 1);
                check("win_deaths", deaths, 0);
            end
        end
        @(negedge clk);
        check("win_held_ack", ack1, 1);
        check("win_play_busy", busy, 0);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        check("win_held_s", s, 1);

        // Simultaneous d and win count as a death; then saturate deaths.
        @(posedge clk); #1;
        d = 1'b1; win = 1'b1;
        @(posedge clk); #1;
        d = 1'b0; win = 1'b0;
        @(negedge clk);
        check("both_deaths", deaths, 1);
        check("both_wins", wins, 1);
        wait_play();
        for (int i = 0; i < 4; i++) begin
            end_game(1'b1);
            wait_play();
        end
        check("sat_deaths", deaths, 3);

        // Reset during OVER with wins=2.
        end_game(1'b0);
        check("over_wins2", wins, 2);
        check("over_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("midrst_wins", wins, 0);
        check("midrst_deaths", deaths, 0);
        check("midrst_gr", game_reset, 1);
        check("midrst_nsew", {n, s, e, w}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_play();

        // Reset while a move pulse is on the outputs drops it.
        @(posedge clk); #1;
        req0 = 1'b1; dir0 = 2'b11;
        @(posedge clk); #1;
        check("pend_w", w, 1);
        req0 = 1'b0;
        reset = 1'b1;
        #1;
        check("pend_w_dropped", w, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        wait_play();

        // Randomized traffic; requests are held until the model says they were granted.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 599) == 0) reset = 1'b1;
            if (!req0 || last_g0) begin
                req0 = 1'($urandom_range(0, 1));
                dir0 = 2'($urandom_range(0, 3));
            end
            if (!req1 || last_g1) begin
                req1 = 1'($urandom_range(0, 1));
                dir1 = 2'($urandom_range(0, 3));
            end
            d   = ($urandom_range(0, 24) == 0);
            win = ($urandom_range(0, 24) == 0);
        end

        @(posedge clk); #1;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; d = 1'b0; win = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
